// File: rtl/shift_frame_reader.sv
// Readout sequencer for the 33-bit TDC shift chain: gates sh_en for 33 clocks,
// captures the frame, checks the marker bit and queues the payload in a show-ahead FIFO.
module shift_frame_reader #(
  parameter int   FIFO_DEPTH = 4,
  parameter logic MARKER     = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_req,
  input  logic        continuous,
  output logic        sh_en,
  input  logic [32:0] sh_data,
  output logic [31:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        busy,
  output logic        err_marker,
  output logic        err_overflow,
  input  logic        clear_err,
  output logic [15:0] words_captured
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [5:0]    bit_cnt_r, bit_cnt_s;
  logic          sh_en_r, busy_r;
  logic [32:0]   capture_r;

  logic [31:0]   fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_r, rd_ptr_s;
  logic [AW-1:0] wr_ptr_r, wr_ptr_s;
  logic [CW-1:0] fifo_cnt_r, fifo_cnt_s;
  logic [31:0]   word_out_r, head_s;
  logic          word_valid_r;

  logic          in_check_s, marker_bad_s, fifo_full_s;
  logic          push_s, pop_s, overflow_s;
  logic          err_marker_r, err_overflow_r;
  logic [15:0]   words_captured_r;

  // Next-state and bit counter; sh_en/busy are registered from the next state
  always_comb begin
    state_s   = state_r;
    bit_cnt_s = bit_cnt_r;
    case (state_r)
      IDLE: begin
        if (frame_req || continuous) begin
          state_s   = SHIFT;
          bit_cnt_s = 6'd0;
        end else begin
          state_s   = IDLE;
        end
      end
      SHIFT: begin
        if (bit_cnt_r == 6'd32) begin
          state_s   = SETTLE;
          bit_cnt_s = 6'd0;
        end else begin
          bit_cnt_s = bit_cnt_r + 6'd1;
        end
      end
      SETTLE: begin
        state_s = CHECK;
      end
      CHECK: begin
        bit_cnt_s = 6'd0;
        if (continuous) begin
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s   = IDLE;
        bit_cnt_s = 6'd0;
      end
    endcase
  end

  // Sequencer state, shift gate and busy flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      bit_cnt_r <= 6'd0;
      sh_en_r   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      bit_cnt_r <= bit_cnt_s;
      sh_en_r   <= (state_s == SHIFT);
      busy_r    <= (state_s != IDLE);
    end
  end

  // Frame capture at the end of the settle cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      capture_r <= 33'd0;
    end else if (state_r == SETTLE) begin
      capture_r <= sh_data;
    end else begin
      capture_r <= capture_r;
    end
  end

  // Frame verdict; a same-cycle pop frees a slot for a full FIFO
  always_comb begin
    pop_s        = word_valid_r && word_ready;
    in_check_s   = (state_r == CHECK);
    fifo_full_s  = (fifo_cnt_r == CNT_FULL);
    marker_bad_s = in_check_s && (capture_r[32] != MARKER);
    overflow_s   = in_check_s && !marker_bad_s && fifo_full_s && !pop_s;
    push_s       = in_check_s && !marker_bad_s && (!fifo_full_s || pop_s);
  end

  // FIFO pointer/count update and the head word presented next cycle
  always_comb begin
    rd_ptr_s   = rd_ptr_r;
    wr_ptr_s   = wr_ptr_r;
    fifo_cnt_s = fifo_cnt_r;
    head_s     = 32'd0;
    if (pop_s) begin
      rd_ptr_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_s = rd_ptr_r;
    end
    if (push_s) begin
      wr_ptr_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_s = wr_ptr_r;
    end
    if (push_s && !pop_s) begin
      fifo_cnt_s = fifo_cnt_r + CNT_ONE;
    end else if (pop_s && !push_s) begin
      fifo_cnt_s = fifo_cnt_r - CNT_ONE;
    end else begin
      fifo_cnt_s = fifo_cnt_r;
    end
    // A push landing on the new head slot is not in memory yet, so bypass it
    if (fifo_cnt_s == CNT_ZERO) begin
      head_s = 32'd0;
    end else if (push_s && (wr_ptr_r == rd_ptr_s)) begin
      head_s = capture_r[31:0];
    end else begin
      head_s = fifo_mem_r[rd_ptr_s];
    end
  end

  // Payload storage
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= capture_r[31:0];
    end
  end

  // FIFO control and registered head outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_r     <= '0;
      wr_ptr_r     <= '0;
      fifo_cnt_r   <= '0;
      word_out_r   <= 32'd0;
      word_valid_r <= 1'b0;
    end else begin
      rd_ptr_r     <= rd_ptr_s;
      wr_ptr_r     <= wr_ptr_s;
      fifo_cnt_r   <= fifo_cnt_s;
      word_out_r   <= head_s;
      word_valid_r <= (fifo_cnt_s != CNT_ZERO);
    end
  end

  // Sticky error flags (a new event beats clear_err) and saturating capture count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_marker_r     <= 1'b0;
      err_overflow_r   <= 1'b0;
      words_captured_r <= 16'd0;
    end else begin
      if (marker_bad_s) begin
        err_marker_r <= 1'b1;
      end else if (clear_err) begin
        err_marker_r <= 1'b0;
      end else begin
        err_marker_r <= err_marker_r;
      end
      if (overflow_s) begin
        err_overflow_r <= 1'b1;
      end else if (clear_err) begin
        err_overflow_r <= 1'b0;
      end else begin
        err_overflow_r <= err_overflow_r;
      end
      if (push_s && (words_captured_r != 16'hFFFF)) begin
        words_captured_r <= words_captured_r + 16'd1;
      end else begin
        words_captured_r <= words_captured_r;
      end
    end
  end

  assign sh_en          = sh_en_r;
  assign busy           = busy_r;
  assign word_out       = word_out_r;
  assign word_valid     = word_valid_r;
  assign err_marker     = err_marker_r;
  assign err_overflow   = err_overflow_r;
  assign words_captured = words_captured_r;

endmodule

// File: tb/tb_shift_frame_reader.sv
// Bench for shift_frame_reader: a behavioural shift chain feeds frames, and a
// queue-based FIFO/error model predicts the readout side.
module tb_shift_frame_reader;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n, frame_req, continuous, word_ready, clear_err;
  logic        sh_en, word_valid, busy, err_marker, err_overflow;
  logic [32:0] sh_data;
  logic [31:0] word_out;
  logic [15:0] words_captured;

  shift_frame_reader #(.FIFO_DEPTH(DEPTH), .MARKER(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .frame_req(frame_req), .continuous(continuous),
    .sh_en(sh_en), .sh_data(sh_data), .word_out(word_out), .word_valid(word_valid),
    .word_ready(word_ready), .busy(busy), .err_marker(err_marker),
    .err_overflow(err_overflow), .clear_err(clear_err), .words_captured(words_captured)
  );

  always #5 clk = ~clk;

  // Shift chain model: first bit shifted in (frame bit 32) ends up at sh_data[32]
  logic [32:0] frames [64];
  int          fidx, bit_idx, wr_f;
  logic [32:0] chain;
  assign sh_data = chain;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_idx <= 0;
      if (bit_idx != 0) fidx <= fidx + 1;
    end else if (sh_en) begin
      chain   <= {chain[31:0], frames[fidx][32 - bit_idx]};
      bit_idx <= (bit_idx == 32) ? 0 : bit_idx + 1;
      if (bit_idx == 32) fidx <= fidx + 1;
    end
  end

  // Reference model state
  logic [31:0] exp_q [$];
  int          exp_cap;
  logic        exp_em, exp_eo;
  int          pass_cnt = 0, total_cnt = 0;

  logic rec_sh [200];
  logic rec_wv [200];
  logic rec_bz [200];
  logic rec_eo [200];
  int   sh_total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One completed frame as seen by the readout rules
  task automatic model_frame(input logic [32:0] f, input bit pop);
    if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
    if (f[32] !== 1'b1) exp_em = 1'b1;
    else if (exp_q.size() >= DEPTH) exp_eo = 1'b1;
    else begin
      exp_q.push_back(f[31:0]);
      if (exp_cap < 65535) exp_cap++;
    end
  endtask

  function automatic logic [32:0] rand_frame(input logic mk);
    return {mk, 32'($urandom)};
  endfunction

  // Called at a negedge: request, edge E0, then sample n negedges (index k = after E_k)
  task automatic window(input int n, input int ready_k, input int clr_k,
                        input int contoff_k, input int req2_k);
    frame_req = 1'b1;
    @(posedge clk);
    sh_total = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) frame_req = 1'b0;
      rec_sh[k] = sh_en; rec_wv[k] = word_valid; rec_bz[k] = busy; rec_eo[k] = err_overflow;
      if (sh_en === 1'b1) sh_total++;
      if (k == ready_k) word_ready = 1'b1;
      if (k == ready_k + 1) word_ready = 1'b0;
      if (k == clr_k) clear_err = 1'b1;
      if (k == clr_k + 1) clear_err = 1'b0;
      if (k == contoff_k) continuous = 1'b0;
      if (k == req2_k) frame_req = 1'b1;
      if (k == req2_k + 1) frame_req = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_valid"}, word_valid, 1);
      chk({tag, "_word"}, word_out, exp_q[0]);
      word_ready = 1'b1;
      @(negedge clk);
      void'(exp_q.pop_front());
    end
    word_ready = 1'b0;
    chk({tag, "_empty"}, word_valid, 0);
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_cap"}, words_captured, exp_cap);
    chk({tag, "_em"}, err_marker, exp_em);
    chk({tag, "_eo"}, err_overflow, exp_eo);
  endtask

  logic [32:0] f;

  initial begin
    fidx = 0; wr_f = 0; chain = 33'd0;
    exp_cap = 0; exp_em = 1'b0; exp_eo = 1'b0;
    for (int i = 0; i < 64; i++) frames[i] = 33'd0;
    reset_n = 1'b0; frame_req = 1'b0; continuous = 1'b0; word_ready = 1'b0; clear_err = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_sh_en", sh_en, 0);
    chk("rst_valid", word_valid, 0);
    chk("rst_word", word_out, 0);
    chk("rst_busy", busy, 0);
    chk_status("rst");

    // Single frame with the fixed pattern
    f = {1'b1, 32'hA5A5_1234};
    frames[wr_f++] = f;
    window(40, -1, -1, -1, -1);
    model_frame(f, 0);
    chk("single_sh_count", sh_total, 33);
    chk("single_sh_e32", rec_sh[32], 1);
    chk("single_sh_e33", rec_sh[33], 0);
    chk("single_wv_e34", rec_wv[34], 0);
    chk("single_wv_e35", rec_wv[35], 1);
    chk("single_busy_e34", rec_bz[34], 1);
    chk("single_busy_e35", rec_bz[35], 0);
    chk("single_word", word_out, 32'hA5A5_1234);
    chk_status("single");
    drain("single_pop");

    // Marker fault, then a second fault with clear_err in its check cycle
    f = rand_frame(1'b0);
    frames[wr_f++] = f;
    window(40, -1, -1, -1, -1);
    model_frame(f, 0);
    chk("marker_valid", word_valid, 0);
    chk_status("marker");
    f = rand_frame(1'b0);
    frames[wr_f++] = f;
    window(40, -1, 34, -1, -1);
    model_frame(f, 0);
    chk_status("marker_clr_race");
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    exp_em = 1'b0;
    chk_status("marker_cleared");

    // Second request while busy is ignored
    f = rand_frame(1'b1);
    frames[wr_f++] = f;
    window(80, -1, -1, -1, 9);
    model_frame(f, 0);
    chk("busyreq_sh_count", sh_total, 33);
    chk("busyreq_busy_e35", rec_bz[35], 0);
    chk("busyreq_busy_e70", rec_bz[70], 0);
    chk_status("busyreq");
    drain("busyreq_pop");

    // Reset asserted mid-frame after edge E20
    f = rand_frame(1'b1);
    frames[wr_f++] = f;
    frame_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    frame_req = 1'b0;
    repeat (20) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    exp_q.delete(); exp_cap = 0; exp_em = 1'b0; exp_eo = 1'b0;
    chk("midrst_sh_en", sh_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", word_valid, 0);
    chk("midrst_word", word_out, 0);
    chk_status("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    f = rand_frame(1'b1);
    frames[wr_f++] = f;
    window(40, -1, -1, -1, -1);
    model_frame(f, 0);
    chk("postrst_sh_count", sh_total, 33);
    chk("postrst_wv_e34", rec_wv[34], 0);
    chk("postrst_wv_e35", rec_wv[35], 1);
    chk_status("postrst");
    drain("postrst_pop");

    // Continuous mode, no consumer: five good frames into a 4-deep FIFO
    for (int i = 0; i < 5; i++) begin
      f = rand_frame(1'b1);
      frames[wr_f++] = f;
      model_frame(f, 0);
    end
    continuous = 1'b1;
    window(180, -1, -1, 150, -1);
    chk("ovf_sh_count", sh_total, 165);
    chk("ovf_gap_e33", rec_sh[33], 0);
    chk("ovf_gap_e34", rec_sh[34], 0);
    chk("ovf_restart_e35", rec_sh[35], 1);
    chk("ovf_eo_e140", rec_eo[140], 0);
    chk("ovf_eo_e175", rec_eo[175], 1);
    chk("ovf_busy_e175", rec_bz[175], 0);
    chk_status("ovf");
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    exp_eo = 1'b0;
    chk_status("ovf_cleared");

    // Full FIFO with a pop in the check cycle: push honoured, no overflow
    f = rand_frame(1'b1);
    frames[wr_f++] = f;
    window(40, 34, -1, -1, -1);
    model_frame(f, 1);
    chk("fullpop_eo_e35", rec_eo[35], 0);
    chk_status("fullpop");
    drain("fullpop_drain");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
